// File: rtl/nivel2_temporizador.sv
// Countdown timer stage for the magnetron control level.
// Holds MM:SS as four BCD digits, loaded by shifting keypad digits in from the
// right, and decrements once per second while the magnetron is on.
//
// state | meaning
// ------+----------------------------------------
// IDLE  | time is 00:00, nothing to count
// ARMED | time nonzero, paused (prescaler phase held)
// RUN   | counting down, one decrement per second
module nivel2_temporizador #(
  parameter int TICKS_PER_SEC = 100,
  parameter int PRESC_W       = 7
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clearn,
  input  logic       magnetron_on,
  input  logic       keypad_valid,
  input  logic [3:0] keypad_digit,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       timer_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

  state_t             state;
  logic [15:0]        digits;
  logic [PRESC_W-1:0] presc;
  logic               running_q;

  logic [15:0] digits_shifted;
  logic [15:0] digits_dec;
  logic        key_ok;
  logic        tick;

  // BCD countdown with borrow; seconds tens wraps to 5 so MM:SS rolls over
  // correctly, while entered seconds >= 60 simply count down as plain BCD.
  function automatic logic [15:0] bcd_dec(input logic [15:0] d);
    logic [3:0] mt, mo, st, so;
    logic       borrow;
    {mt, mo, st, so} = d;
    borrow = 1'b0;
    if (so == 4'd0) begin
      so = 4'd9;
      borrow = 1'b1;
    end else begin
      so = so - 4'd1;
    end
    if (borrow) begin
      if (st == 4'd0) begin
        st = 4'd5;
      end else begin
        st = st - 4'd1;
        borrow = 1'b0;
      end
    end
    if (borrow) begin
      if (mo == 4'd0) begin
        mo = 4'd9;
      end else begin
        mo = mo - 4'd1;
        borrow = 1'b0;
      end
    end
    if (borrow) begin
      mt = mt - 4'd1;
    end
    return {mt, mo, st, so};
  endfunction

  // Next-value candidates for keypad shift and one-second decrement
  always_comb begin
    key_ok         = keypad_valid && (keypad_digit <= 4'd9) && (state != RUN);
    digits_shifted = {digits[11:0], keypad_digit};
    digits_dec     = bcd_dec(digits);
    tick           = (state == RUN) && magnetron_on && (presc == PRESC_MAX);
  end

  // Control FSM with digit, prescaler and running registers; clear wins over
  // tick, tick wins over keypad (keypad is never accepted while counting)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      digits    <= 16'h0000;
      presc     <= '0;
      running_q <= 1'b0;
    end else if (!clearn) begin
      state     <= IDLE;
      digits    <= 16'h0000;
      presc     <= '0;
      running_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          presc <= '0;
          if (key_ok) begin
            digits <= digits_shifted;
            if (digits_shifted != 16'h0000) begin
              state <= ARMED;
            end
          end
          running_q <= 1'b0;
        end
        ARMED: begin
          // A shift can push the only nonzero digit out (e.g. 10:00 + '0')
          if (key_ok && (digits_shifted == 16'h0000)) begin
            digits    <= digits_shifted;
            presc     <= '0;
            state     <= IDLE;
            running_q <= 1'b0;
          end else begin
            if (key_ok) begin
              digits <= digits_shifted;
            end
            if (magnetron_on) begin
              state     <= RUN;
              running_q <= 1'b1;
            end else begin
              running_q <= 1'b0;
            end
          end
        end
        RUN: begin
          if (!magnetron_on) begin
            state     <= ARMED;
            running_q <= 1'b0;
          end else if (tick) begin
            presc  <= '0;
            digits <= digits_dec;
            if (digits_dec == 16'h0000) begin
              state     <= IDLE;
              running_q <= 1'b0;
            end
          end else begin
            presc <= presc + PRESC_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          digits    <= 16'h0000;
          presc     <= '0;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign min_tens   = digits[15:12];
  assign min_ones   = digits[11:8];
  assign sec_tens   = digits[7:4];
  assign sec_ones   = digits[3:0];
  assign running    = running_q;
  assign timer_done = (digits == 16'h0000);

endmodule
